// File: rtl/bus_drive_sequencer.sv
// bus_drive_sequencer: turns a 5-bit bus source code into registered one-hot
// drive enables for 24 sources; optional break-before-make (BUS_TURNAROUND_EN).
//
// Ports:
//   clock     rising-edge clock
//   clear     async active-high reset
//   src_code  requested source (0-15 R0-R15, 16 HI, 17 LO, 18 ZHI,
//             19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C)
//   src_valid request active, held while the source must drive
//   drv_en    registered one-hot drive enables, bit k = code k
//   cur_code  code currently driving, 0 when nothing drives
//   drv_ack   one-cycle pulse on the first cycle of a new grant
//   busy      high while in turnaround (always 0 without the macro)
//   bad_code  one-cycle pulse for an out-of-range code with src_valid
//
// Build option: BUS_TURNAROUND_EN adds the TURN state, counter and busy.
module bus_drive_sequencer #(
  parameter int NUM_SRC     = 24,
  parameter int TURN_CYCLES = 1
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [4:0]         src_code,
  input  logic               src_valid,
  output logic [NUM_SRC-1:0] drv_en,
  output logic [4:0]         cur_code,
  output logic               drv_ack,
  output logic               busy,
  output logic               bad_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Request is captured first; the FSM acts on the captured copy so that
  // every output is a flop and a request sampled at edge N lands at N+1.
  logic       req_v;
  logic [4:0] req_code;
  logic       req_in;
  logic       req_ok;
  logic       req_bad;

  logic [4:0]         code_d;
  logic               ack_d;
  logic [NUM_SRC-1:0] drv_d;

  assign req_in  = {1'b0, req_code} < 6'(NUM_SRC);
  assign req_ok  = req_v && req_in;
  assign req_bad = req_v && !req_in;

`ifdef BUS_TURNAROUND_EN
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] pend_q, pend_d;
`else
  logic unused_turn;
  assign unused_turn = |3'(TURN_CYCLES);
`endif

  always_comb begin
    state_d = state_q;
    code_d  = cur_code;
    ack_d   = 1'b0;
`ifdef BUS_TURNAROUND_EN
    cnt_d   = cnt_q;
    pend_d  = pend_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_ok) begin
          state_d = DRIVE;
          code_d  = req_code;
          ack_d   = 1'b1;
        end
      end
      DRIVE: begin
        if (!req_ok) begin
          state_d = IDLE;
          code_d  = '0;
        end else if (req_code != cur_code) begin
`ifdef BUS_TURNAROUND_EN
          state_d = TURN;
          code_d  = '0;
          pend_d  = req_code;
          cnt_d   = 3'(TURN_CYCLES - 1);
`else
          code_d  = req_code;
          ack_d   = 1'b1;
`endif
        end
      end
`ifdef BUS_TURNAROUND_EN
      TURN: begin
        if (!req_ok) begin
          state_d = IDLE;
          code_d  = '0;
          cnt_d   = '0;
          pend_d  = '0;
        end else if (cnt_q == 3'd0) begin
          state_d = DRIVE;
          code_d  = pend_q;
          ack_d   = 1'b1;
        end else begin
          // latest request wins; countdown is not restarted
          cnt_d  = cnt_q - 3'd1;
          pend_d = req_code;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        code_d  = '0;
      end
    endcase
  end

  always_comb begin
    drv_d = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      drv_d[k] = (state_d == DRIVE) && (code_d == 5'(k));
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      req_v    <= 1'b0;
      req_code <= '0;
      state_q  <= IDLE;
      cur_code <= '0;
      drv_en   <= '0;
      drv_ack  <= 1'b0;
      bad_code <= 1'b0;
    end else begin
      req_v    <= src_valid;
      req_code <= src_code;
      state_q  <= state_d;
      cur_code <= code_d;
      drv_en   <= drv_d;
      drv_ack  <= ack_d;
      bad_code <= req_bad;
    end
  end

`ifdef BUS_TURNAROUND_EN
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_q  <= '0;
      pend_q <= '0;
      busy   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      busy   <= (state_d == TURN);
    end
  end
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_bus_drive_sequencer.sv
// tb_bus_drive_sequencer: directed checks of grant, switch, release,
// invalid-code and async-clear behaviour of bus_drive_sequencer.
module tb_bus_drive_sequencer;

`ifdef BUS_TURNAROUND_EN
  localparam int TC = 3;
`else
  localparam int TC = 0;
`endif

  logic        clock;
  logic        clear;
  logic [4:0]  src_code;
  logic        src_valid;
  logic [23:0] drv_en;
  logic [4:0]  cur_code;
  logic        drv_ack;
  logic        busy;
  logic        bad_code;

  int checks = 0;
  int errors = 0;

  bus_drive_sequencer #(
    .NUM_SRC    (24),
    .TURN_CYCLES(TC == 0 ? 1 : TC)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .src_code (src_code),
    .src_valid(src_valid),
    .drv_en   (drv_en),
    .cur_code (cur_code),
    .drv_ack  (drv_ack),
    .busy     (busy),
    .bad_code (bad_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle2();
    src_valid = 1'b0;
    src_code  = '0;
    tick();
    tick();
  endtask

  // switch from a driving source to code c with expected enable e
  task automatic sw(input logic [4:0] c, input logic [31:0] e);
    src_valid = 1'b1;
    src_code  = c;
    tick();
    for (int i = 0; i < TC; i++) begin
      tick();
      chk("turn_en", {8'b0, drv_en}, 32'h0);
      chk("turn_busy", {31'b0, busy}, 32'h1);
    end
    tick();
    chk("sw_en", {8'b0, drv_en}, e);
    chk("sw_code", {27'b0, cur_code}, {27'b0, c});
    chk("sw_ack", {31'b0, drv_ack}, 32'h1);
    chk("sw_busy", {31'b0, busy}, 32'h0);
  endtask

  always @(negedge clock) begin
    chk("onehot", 32'($countones(drv_en) <= 1), 32'h1);
  end

  initial begin
    clear     = 1'b1;
    src_valid = 1'b0;
    src_code  = '0;
    tick();
    tick();
    chk("rst_en", {8'b0, drv_en}, 32'h0);
    chk("rst_code", {27'b0, cur_code}, 32'h0);
    clear = 1'b0;

    // grant from idle, code 1
    src_valid = 1'b1;
    src_code  = 5'd1;
    tick();
    chk("lat_en", {8'b0, drv_en}, 32'h0);
    tick();
    chk("g1_en", {8'b0, drv_en}, 32'h000002);
    chk("g1_code", {27'b0, cur_code}, 32'd1);
    chk("g1_ack", {31'b0, drv_ack}, 32'h1);
    tick();
    chk("hold_ack", {31'b0, drv_ack}, 32'h0);
    chk("hold_en", {8'b0, drv_en}, 32'h000002);

    // ownership changes
    sw(5'd20, 32'h100000);
    tick();
    chk("pc_ack", {31'b0, drv_ack}, 32'h0);
    sw(5'd16, 32'h010000);
    sw(5'd21, 32'h200000);

    // drop request -> idle
    idle2();
    chk("drop_en", {8'b0, drv_en}, 32'h0);
    chk("drop_code", {27'b0, cur_code}, 32'h0);

    // grant 2, then request 9 and release
    src_valid = 1'b1;
    src_code  = 5'd2;
    tick();
    tick();
    chk("g2_en", {8'b0, drv_en}, 32'h000004);
    src_code = 5'd9;
    tick();
    tick();
`ifdef BUS_TURNAROUND_EN
    chk("mt_busy1", {31'b0, busy}, 32'h1);
    src_valid = 1'b0;
    tick();
    chk("mt_busy2", {31'b0, busy}, 32'h1);
    chk("mt_en2", {8'b0, drv_en}, 32'h0);
    tick();
    chk("mt_busy3", {31'b0, busy}, 32'h0);
    chk("mt_en3", {8'b0, drv_en}, 32'h0);
    chk("mt_ack3", {31'b0, drv_ack}, 32'h0);
    tick();
    chk("mt_en4", {8'b0, drv_en}, 32'h0);
    chk("mt_ack4", {31'b0, drv_ack}, 32'h0);
`else
    chk("g9_en", {8'b0, drv_en}, 32'h000200);
    chk("g9_ack", {31'b0, drv_ack}, 32'h1);
    chk("g9_busy", {31'b0, busy}, 32'h0);
`endif
    idle2();

    // invalid code 27 while driving 4
    src_valid = 1'b1;
    src_code  = 5'd4;
    tick();
    tick();
    chk("g4_en", {8'b0, drv_en}, 32'h000010);
    src_code = 5'd27;
    tick();
    src_valid = 1'b0;
    src_code  = 5'd0;
    tick();
    chk("bad_en", {8'b0, drv_en}, 32'h0);
    chk("bad_code", {27'b0, cur_code}, 32'h0);
    chk("bad_pulse", {31'b0, bad_code}, 32'h1);
    tick();
    chk("bad_end", {31'b0, bad_code}, 32'h0);

    // boundary: 24 invalid from idle, 23 (C) valid
    src_valid = 1'b1;
    src_code  = 5'd24;
    tick();
    tick();
    chk("b24_bad", {31'b0, bad_code}, 32'h1);
    chk("b24_en", {8'b0, drv_en}, 32'h0);
    src_code = 5'd23;
    tick();
    tick();
    chk("b23_en", {8'b0, drv_en}, 32'h800000);
    chk("b23_ack", {31'b0, drv_ack}, 32'h1);
    chk("b23_bad", {31'b0, bad_code}, 32'h0);
    idle2();

    // async clear mid-drive of code 5
    src_valid = 1'b1;
    src_code  = 5'd5;
    tick();
    tick();
    chk("g5_en", {8'b0, drv_en}, 32'h000020);
    #2 clear = 1'b1;
    #1;
    chk("ac_en", {8'b0, drv_en}, 32'h0);
    chk("ac_code", {27'b0, cur_code}, 32'h0);
    chk("ac_ack", {31'b0, drv_ack}, 32'h0);
    chk("ac_busy", {31'b0, busy}, 32'h0);
    chk("ac_bad", {31'b0, bad_code}, 32'h0);
    tick();
    clear = 1'b0;
    tick();
    chk("rel_en", {8'b0, drv_en}, 32'h0);
    tick();
    chk("rel_g5", {8'b0, drv_en}, 32'h000020);
    chk("rel_ack", {31'b0, drv_ack}, 32'h1);
    idle2();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_drive_sequencer.md
# bus_drive_sequencer

- Decoder-side counterpart of the bus source encoder.
- Takes a 5-bit bus source code plus a valid strobe and produces registered one-hot drive enables for the 24 datapath bus sources: R0–R15, HI, LO, ZHI, ZLO, PC, MDR, InPort, C.
- Sits between the control unit and the datapath bus multiplexer.
- Guarantees that at most one source drives the bus, with optional break-before-make turnaround when ownership changes.

## Interface
Parameters:
- NUM_SRC, 24, number of decodable sources. Codes 0..NUM_SRC-1 are valid.
- TURN_CYCLES, 1, idle cycles inserted on an ownership change (range 1..7). Only used when BUS_TURNAROUND_EN is defined.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-high reset
- src_code  in  5  requested source. Code map: 0–15 = R0–R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C.
- src_valid  in  1  request active. Held for as long as the source must drive.
- drv_en  out  NUM_SRC  registered one-hot drive enables. Bit k corresponds to code k.
- cur_code  out  5  code currently driving. 0 when no source is driving.
- drv_ack  out  1  one-cycle pulse in the first cycle a newly granted source drives
- busy  out  1  high in TURN state
- bad_code  out  1  one-cycle pulse: an invalid code was presented with src_valid high

## Operation
States:
- IDLE: drv_en all 0.
- DRIVE: exactly one drv_en bit high, the bit for cur_code.
- TURN: drv_en all 0. Pending code held internally. Turnaround counter runs.

Transitions are evaluated each rising edge:
- IDLE, src_valid=1, code valid -> DRIVE. cur_code <= src_code, drv_ack=1.
- IDLE, src_valid=0 -> IDLE.
- DRIVE, src_valid=1, src_code==cur_code -> DRIVE. No ack.
- DRIVE, src_valid=1, valid different code:
  - With the macro: -> TURN. pending <= src_code, counter <= TURN_CYCLES-1.
  - Without the macro: -> DRIVE with the new code, drv_ack=1.
- DRIVE, src_valid=0 -> IDLE. cur_code <= 0. No turnaround needed.
- TURN, counter==0, src_valid=1 -> DRIVE with pending, drv_ack=1.
- TURN, counter!=0 -> counter decrements.
- TURN, src_valid=0 (at any counter value) -> IDLE.
- TURN, a different valid code arrives -> pending is overwritten with the latest code. The counter is not restarted.

Invalid code (src_code >= NUM_SRC) with src_valid=1:
- Treated as src_valid=0 for the transition: DRIVE and TURN go to IDLE, IDLE stays IDLE.
- bad_code pulses in the following cycle.

Output invariants:
- drv_en is a pure registered function of state and cur_code.
- popcount(drv_en) <= 1 in every cycle.

## Timing
- Reset values while clear is high, applied asynchronously:
  - State = IDLE.
  - drv_en, cur_code, drv_ack, busy and bad_code are all 0.
  - Pending code and counter are 0.
- clear deasserting mid-TURN or mid-DRIVE: there is no residual state. The first edge after release evaluates from IDLE.
- Latency, request sampled at edge N:
  - From IDLE: enable high after edge N+1.
  - Switch with the macro: drv_en is 0 for TURN_CYCLES cycles, and the new enable is high after edge N+1+TURN_CYCLES.
  - Switch without the macro: the new enable replaces the old one at edge N+1. There is no gap cycle.
- drv_ack and bad_code each last exactly one cycle.
- busy equals (state==TURN).

## Configuration
- BUS_TURNAROUND_EN, defined: TURN state, counter and busy are compiled in. Break-before-make applies on every ownership change.
- BUS_TURNAROUND_EN, undefined:
  - TURN logic is removed and busy is tied to 0.
  - TURN_CYCLES is ignored.
  - Ownership changes are direct DRIVE->DRIVE. The one-hot invariant still holds.

## Test plan
- Reset: assert clear mid-DRIVE (code 5) -> drv_en=0, cur_code=0 and every flag 0 immediately, without waiting for a clock edge.
- Grant from IDLE: src_valid=1, code 1 at edge N -> drv_en=0x000002, cur_code=1 and drv_ack=1 after edge N+1. drv_ack=0 in the next cycle while the request is held.
- Switch with the macro, TURN_CYCLES=1: code 1 then code 20 at edge N -> drv_en=0 and busy=1 for one cycle, then drv_en=0x100000 (PC) with drv_ack=1.
- Switch without the macro: code 16 then code 21 -> drv_en goes 0x010000 -> 0x200000 on consecutive cycles. Check popcount<=1 in every cycle.
- Release mid-turn: with the macro and TURN_CYCLES=3, switch 2->9, then drop src_valid during the second TURN cycle -> IDLE, drv_en stays 0, no drv_ack.
- Invalid code: code 27 with src_valid=1 while driving code 4 -> next cycle drv_en=0, cur_code=0, bad_code=1 for exactly one cycle.
